// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: requester handshake, read-return and VRAM bus signals of the VRAM arbiter
interface vram_arbiter_if;
   logic [3:0]       req;
   logic [3:0][14:0] addr;
   logic [31:0]      wrdata0;
   logic [3:0]       wrbytesel0;
   logic             write0;
   logic [3:0]       ack;
   logic [3:0][31:0] rddata;
   logic [3:0]       rdvalid;
   logic [14:0]      bus_addr;
   logic [31:0]      bus_wrdata;
   logic [3:0]       bus_wrbytesel;
   logic             bus_write;
   logic [31:0]      bus_rddata;
   modport master (
      output req, addr, wrdata0, wrbytesel0, write0, bus_rddata,
      input  ack, rddata, rdvalid, bus_addr, bus_wrdata, bus_wrbytesel, bus_write
   );
   modport slave (
      input  req, addr, wrdata0, wrbytesel0, write0, bus_rddata,
      output ack, rddata, rdvalid, bus_addr, bus_wrdata, bus_wrbytesel, bus_write
   );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: one VRAM access per clock; port 0 priority with starvation guard, ports 1-3 round-robin
module vram_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic          clk,
   input logic          rst_n,
   vram_arbiter_if.slave vif
);
   logic [3:0] starve_cnt;
   logic [1:0] rr_ptr, c1, c2, c3, win, rd_port;
   logic       block0, render_req, port0_win, win_vld, render_win, port0_wr, rd_pend;
   assign block0     = starve_cnt == 4'(STARVE_LIMIT);
   assign render_req = |vif.req[3:1];
   assign port0_win  = vif.req[0] && !block0;
   assign port0_wr   = port0_win && vif.write0;
   assign win_vld    = port0_win || render_req;
   assign render_win = win_vld && !port0_win;
   // rotation order after the last render winner: rr_ptr+1, +2, +3 wrapping over 1..3
   assign c1 = rr_ptr == 2'd3 ? 2'd1 : rr_ptr + 2'd1;
   assign c2 = c1 == 2'd3 ? 2'd1 : c1 + 2'd1;
   assign c3 = c2 == 2'd3 ? 2'd1 : c2 + 2'd1;
   always_comb begin
      win               = port0_win ? 2'd0 : vif.req[c1] ? c1 : vif.req[c2] ? c2 : c3;
      vif.ack           = win_vld ? 4'b0001 << win : 4'b0000;
      vif.bus_addr      = win_vld ? vif.addr[win] : 15'd0;
      vif.bus_write     = port0_wr;
      vif.bus_wrbytesel = port0_wr ? vif.wrbytesel0 : 4'b0000;
      vif.bus_wrdata    = port0_win ? vif.wrdata0 : 32'd0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt  <= 4'd0;
         rr_ptr      <= 2'd3;
         rd_pend     <= 1'b0;
         rd_port     <= 2'd0;
         vif.rddata  <= '0;
         vif.rdvalid <= 4'b0000;
      end else begin
         starve_cnt  <= (render_win || !render_req) ? 4'd0 :
                        (port0_win && !block0) ? starve_cnt + 4'd1 : starve_cnt;
         rr_ptr      <= render_win ? win : rr_ptr;
         rd_pend     <= win_vld && !port0_wr;
         rd_port     <= win;
         vif.rdvalid <= rd_pend ? 4'b0001 << rd_port : 4'b0000;
         if (rd_pend)
            vif.rddata[rd_port] <= vif.bus_rddata;
      end
   end
endmodule
